mem_port_arbiter: RTL and testbench

Shares the core's single memory port between the instruction-fetch requester (IF stage, driven from PC) and the data requester (MEM stage load/store). One transaction is outstanding at a time. Responses are routed back to the owning requester. The block drives the pipeline stall enable that gates the PC and IF_ID registers. It sits between the datapath and the memory model/bus.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_starve_cnt.sv | 33 +++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - counts contested data wins and forces a fetch win at STARVE_MAX
// Only instantiated when MEM_ARB_STARVE_EN is defined.
module arb_starve_cnt #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_fire,
  input  logic contested,
  input  logic d_win,
  output logic force_i
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt_q;

  assign force_i = (cnt_q >= CNT_W'(STARVE_MAX));

  // Any fetch win (forced or not) restarts the count; uncontested data wins leave it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (arb_fire) begin
      if (!d_win) begin
        cnt_q <= '0;
      end else if (contested) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port shared by fetch and data requesters
// Define MEM_ARB_STARVE_EN to bound how long fetch can lose contested arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [BE_W-1:0]       d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [BE_W-1:0]       mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall_n
);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       discard_q, discard_d;

  logic                  mem_req_d;
  logic                  mem_we_d;
  logic [BE_W-1:0]       mem_be_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;

  logic any_req;
  logic arb_fire;
  logic force_i;
  logic win_d;

  assign any_req = if_req | d_req;
  assign win_d   = d_req & ~(if_req & force_i);

`ifdef MEM_ARB_STARVE_EN
  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .arb_fire (arb_fire),
    .contested(if_req & d_req),
    .d_win    (win_d),
    .force_i  (force_i)
  );
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = ^32'(STARVE_MAX);
  assign force_i = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_be_d    = mem_be;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    if_rvalid   = 1'b0;
    d_rvalid    = 1'b0;
    if_rdata    = '0;
    d_rdata     = '0;
    arb_fire    = 1'b0;
    stall_n     = 1'b1;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          arb_fire = 1'b1;
          stall_n  = 1'b0;
        end
      end
      REQ: begin
        stall_n = 1'b0;
        if (if_flush && owner_q == OWN_I) discard_d = 1'b1;
        if (mem_gnt) begin
          if_gnt    = (owner_q == OWN_I);
          d_gnt     = (owner_q == OWN_D);
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          // A flush landing on the response cycle itself also kills that fetch.
          if (owner_q == OWN_I) begin
            if_rvalid = ~discard_q & ~if_flush;
            if_rdata  = mem_rdata;
          end else begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end
          discard_d = 1'b0;
          if (any_req) arb_fire = 1'b1;
          else         state_d  = IDLE;
        end else begin
          stall_n = 1'b0;
          if (if_flush && owner_q == OWN_I) discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb_fire) begin
      state_d   = REQ;
      mem_req_d = 1'b1;
      if (win_d) begin
        owner_d     = OWN_D;
        mem_we_d    = d_we;
        mem_be_d    = d_be;
        mem_addr_d  = d_addr;
        mem_wdata_d = d_wdata;
      end else begin
        owner_d     = OWN_I;
        mem_we_d    = 1'b0;
        mem_be_d    = {BE_W{1'b1}};
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      discard_q <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      discard_q <= discard_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_be    <= mem_be_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
// Grant order follows MEM_ARB_STARVE_EN when the macro is defined for the build.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_flush, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          stall_n;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .stall_n(stall_n)
  );

  typedef struct {
    bit          is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } rsp_t;

  typedef enum {P_IDLE, P_REQ, P_RESP} phase_t;

  txn_t gnt_q[$];
  rsp_t rsp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Transaction-level model: one outstanding access, data beats fetch unless starved.
  phase_t      ph = P_IDLE;
  txn_t        cur, i_txn, d_txn;
  bit          discard, i_pend, d_pend;
  int          starve, gnt_left, rsp_left;
  int          gnt_cfg = 0, rsp_cfg = 0;
  bit          rst_now, flush_now, stray_en, force_rv, mon_en;
  bit          exp_stall_n;
  logic [69:0] exp_bus;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic new_fetch();
    i_pend = 1'b1;
    i_txn  = '{1'b0, 1'b0, 4'hF, $urandom & 32'hFFFF_FFFC, 32'h0};
  endtask

  task automatic new_data();
    d_pend = 1'b1;
    d_txn  = '{1'b1, 1'($urandom_range(0, 1)), 4'($urandom), $urandom & 32'hFFFF_FFFC, $urandom};
  endtask

  task automatic arbitrate();
    bit contested;
    bit dwin;
    contested = i_pend && d_pend;
    dwin      = d_pend;
`ifdef MEM_ARB_STARVE_EN
    if (contested && starve >= SMAX) dwin = 1'b0;
    if (!dwin) starve = 0;
    else if (contested) starve++;
`endif
    cur      = dwin ? d_txn : i_txn;
    ph       = P_REQ;
    gnt_left = (gnt_cfg < 0) ? $urandom_range(0, 2) : gnt_cfg;
  endtask

  task automatic cycle();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (!rst_now) begin
      if (ph == P_REQ) begin
        if (gnt_left == 0) mem_gnt = 1'b1;
        else gnt_left--;
      end else if (ph == P_RESP) begin
        if (rsp_left == 0) mem_rvalid = 1'b1;
        else rsp_left--;
      end else begin
        if (stray_en) begin
          mem_gnt    = ($urandom_range(0, 3) == 0);
          mem_rvalid = ($urandom_range(0, 3) == 0);
        end
        if (force_rv) mem_rvalid = 1'b1;
      end
    end
    rst_n    = !rst_now;
    if_req   = i_pend;
    if_addr  = i_txn.addr;
    if_flush = flush_now;
    d_req    = d_pend;
    d_we     = d_txn.we;
    d_be     = d_txn.be;
    d_addr   = d_txn.addr;
    d_wdata  = d_txn.wdata;

    exp_bus     = {ph == P_REQ, cur.we, cur.be, cur.addr, cur.wdata};
    exp_stall_n = !((ph == P_IDLE && (i_pend || d_pend)) || ph == P_REQ ||
                    (ph == P_RESP && !mem_rvalid));

    if (rst_now) begin
      ph      = P_IDLE;
      cur     = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
      discard = 1'b0;
      starve  = 0;
    end else begin
      case (ph)
        P_IDLE: if (i_pend || d_pend) arbitrate();
        P_REQ: begin
          if (flush_now && !cur.is_d) discard = 1'b1;
          if (mem_gnt) begin
            gnt_q.push_back(cur);
            if (cur.is_d) d_pend = 1'b0;
            else i_pend = 1'b0;
            ph       = P_RESP;
            rsp_left = (rsp_cfg < 0) ? $urandom_range(0, 3) : rsp_cfg;
          end
        end
        default: begin
          if (mem_rvalid) begin
            if (cur.is_d) rsp_q.push_back('{1'b1, mem_rdata});
            else if (!discard && !flush_now) rsp_q.push_back('{1'b0, mem_rdata});
            discard = 1'b0;
            if (i_pend || d_pend) arbitrate();
            else ph = P_IDLE;
          end else if (flush_now && !cur.is_d) begin
            discard = 1'b1;
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or a response.
  initial begin : monitor
    txn_t ge;
    rsp_t re;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("stall_n", 128'(stall_n), 128'(exp_stall_n));
        chk("mem_bus", 128'({mem_req, mem_we, mem_be, mem_addr, mem_wdata}), 128'(exp_bus));
        if (if_gnt || d_gnt) begin
          if (gnt_q.size() == 0) begin
            chk("unexpected_gnt", 128'({if_gnt, d_gnt}), 128'(0));
          end else begin
            ge = gnt_q.pop_front();
            chk("gnt_owner", 128'({if_gnt, d_gnt}), ge.is_d ? 128'(2'b01) : 128'(2'b10));
          end
        end
        if (gnt_q.size() != 0) begin
          chk("missing_gnt", 128'({if_gnt, d_gnt}), gnt_q[0].is_d ? 128'(2'b01) : 128'(2'b10));
          gnt_q.delete();
        end
        if (if_rvalid || d_rvalid) begin
          if (rsp_q.size() == 0) begin
            chk("unexpected_rvalid", 128'({if_rvalid, d_rvalid}), 128'(0));
          end else begin
            re = rsp_q.pop_front();
            chk("rvalid_owner", 128'({if_rvalid, d_rvalid}), re.is_d ? 128'(2'b01) : 128'(2'b10));
            chk("rdata", re.is_d ? 128'(d_rdata) : 128'(if_rdata), 128'(re.data));
          end
        end
        if (rsp_q.size() != 0) begin
          chk("missing_rvalid", 128'({if_rvalid, d_rvalid}), rsp_q[0].is_d ? 128'(2'b01) : 128'(2'b10));
          rsp_q.delete();
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    i_txn = '{1'b0, 1'b0, 4'hF, 32'h0, 32'h0};
    d_txn = '{1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
    cur   = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    @(posedge clk);
    #1;
    mon_en  = 1'b1;
    rst_now = 1'b1;
    run(2);
    rst_now = 1'b0;

    // lone fetch, zero-wait memory
    i_pend = 1'b1;
    i_txn  = '{1'b0, 1'b0, 4'hF, 32'h100, 32'h0};
    run(4);

    // simultaneous fetch and load
    i_pend = 1'b1;
    i_txn  = '{1'b0, 1'b0, 4'hF, 32'h104, 32'h0};
    d_pend = 1'b1;
    d_txn  = '{1'b1, 1'b0, 4'hF, 32'h2000, 32'h0};
    run(7);

    // flushed fetch with 3-cycle response delay, then a normal fetch
    rsp_cfg = 3;
    i_pend  = 1'b1;
    i_txn   = '{1'b0, 1'b0, 4'hF, 32'h200, 32'h0};
    run(2);
    flush_now = 1'b1;
    run(1);
    flush_now = 1'b0;
    run(4);
    rsp_cfg = 0;
    i_pend  = 1'b1;
    i_txn   = '{1'b0, 1'b0, 4'hF, 32'h300, 32'h0};
    run(4);

    // store held across two wait cycles
    gnt_cfg = 2;
    d_pend  = 1'b1;
    d_txn   = '{1'b1, 1'b1, 4'b0011, 32'h4000, 32'hCAFE_F00D};
    run(6);
    gnt_cfg = 0;

    // both requesters held continuously
    for (int k = 0; k < 40; k++) begin
      if (!i_pend) new_fetch();
      if (!d_pend) new_data();
      cycle();
    end
    run(12);

    // reset in the middle of a response, stray rvalid right after
    rsp_cfg = 5;
    new_fetch();
    run(3);
    rst_now = 1'b1;
    run(1);
    rst_now  = 1'b0;
    force_rv = 1'b1;
    run(1);
    force_rv = 1'b0;
    run(3);

    // randomized traffic with stray memory strobes, flushes and resets
    gnt_cfg  = -1;
    rsp_cfg  = -1;
    stray_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (!i_pend && $urandom_range(0, 2) == 0) new_fetch();
      if (!d_pend && $urandom_range(0, 2) == 0) new_data();
      flush_now = ($urandom_range(0, 11) == 0);
      rst_now   = ($urandom_range(0, 499) == 0);
      cycle();
    end
    flush_now = 1'b0;
    rst_now   = 1'b0;
    run(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
